// File: rtl/compress_byte_serializer_if.sv
// rtl/compress_byte_serializer_if.sv - tile capture and word-stream bundle for the byte serializer
interface compress_byte_serializer_if #(
    parameter int TILE_SIZE = 8
);
    logic                              i_valid;
    logic [8*TILE_SIZE*TILE_SIZE-1:0]  data_abs_compressed;
    logic [5:0]                        data_abs_compressed_bytesize;
    logic                              o_in_ready;
    logic [31:0]                       o_data;
    logic [3:0]                        o_keep;
    logic                              o_last;
    logic                              o_valid;
    logic                              i_ready;
    logic                              o_overflow;

    // Producer/consumer side: supplies tiles and the downstream ready.
    modport master (
        output i_valid,
        output data_abs_compressed,
        output data_abs_compressed_bytesize,
        output i_ready,
        input  o_in_ready,
        input  o_data,
        input  o_keep,
        input  o_last,
        input  o_valid,
        input  o_overflow
    );

    // Serializer side.
    modport slave (
        input  i_valid,
        input  data_abs_compressed,
        input  data_abs_compressed_bytesize,
        input  i_ready,
        output o_in_ready,
        output o_data,
        output o_keep,
        output o_last,
        output o_valid,
        output o_overflow
    );
endinterface

// File: rtl/compress_byte_serializer.sv
// rtl/compress_byte_serializer.sv - serializes a captured compressed tile into 32-bit words
module compress_byte_serializer #(
    parameter int TILE_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    compress_byte_serializer_if.slave bus
);
    localparam int TILE_W = 8 * TILE_SIZE * TILE_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [TILE_W-1:0]   tile_q;
    // Byte count minus one: a 0 input (meaning 64) wraps to 63, so the
    // upper bits are directly the last word index and the low bits pick
    // the lanes of the last word.
    logic [5:0]          cnt_m1_q;
    logic [3:0]          idx_q;
    logic                ovf_q;

    logic                is_last;
    logic [3:0]          lane_keep;
    logic [31:0]         word_raw;
    logic [31:0]         word_masked;

    logic                in_ready_c;
    logic                valid_c;
    logic [31:0]         data_c;
    logic [3:0]          keep_c;
    logic                last_c;

    assign is_last  = (idx_q == cnt_m1_q[5:2]);
    assign word_raw = tile_q[{idx_q, 5'd0} +: 32];

    // Lane enables: full word except on the last one, which carries 1..4 bytes.
    always_comb begin
        lane_keep = 4'b1111;
        if (is_last) begin
            case (cnt_m1_q[1:0])
                2'd0:    lane_keep = 4'b0001;
                2'd1:    lane_keep = 4'b0011;
                2'd2:    lane_keep = 4'b0111;
                default: lane_keep = 4'b1111;
            endcase
        end
    end

    // Zero the bytes of disabled lanes so padding never leaks tile contents.
    always_comb begin
        word_masked = 32'h0;
        for (int j = 0; j < 4; j++) begin
            if (lane_keep[j]) begin
                word_masked[8*j +: 8] = word_raw[8*j +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and output decode; outputs depend only on registered state.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        valid_c    = 1'b0;
        data_c     = 32'h0;
        keep_c     = 4'b0000;
        last_c     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.i_valid) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                valid_c = 1'b1;
                data_c  = word_masked;
                keep_c  = lane_keep;
                last_c  = is_last;
                if (bus.i_ready && is_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tile capture, word index and sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tile_q   <= '0;
            cnt_m1_q <= 6'd0;
            idx_q    <= 4'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (bus.i_valid) begin
                    tile_q   <= bus.data_abs_compressed;
                    cnt_m1_q <= bus.data_abs_compressed_bytesize - 6'd1;
                    idx_q    <= 4'd0;
                end
            end else begin
                if (bus.i_ready && !is_last) begin
                    idx_q <= idx_q + 4'd1;
                end
                if (bus.i_valid) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_in_ready = in_ready_c;
    assign bus.o_valid    = valid_c;
    assign bus.o_data     = data_c;
    assign bus.o_keep     = keep_c;
    assign bus.o_last     = last_c;
    assign bus.o_overflow = ovf_q;
endmodule
